ifft4_seq: RTL and testbench
============================

// Module: ifft4_seq
// PURPOSE
//   Sequential 4-point inverse FFT; inverse of the combinational fft2 block.
//   Takes 4 complex bins (X0..X3), runs two radix-2 butterfly stages over
//   successive cycles, scales by 1/4, and returns the 4 reconstructed samples
//   plus the packed 4-bit word that fft2 originally transformed.
//   Sits downstream of fft2 in loopback/self-check paths. Valid/ready on both sides.
// PARAMETERS
//   DW  4  signed two's-complement width of each bin re/im and of each output sample
//   (internal accumulator width DW+2 is a localparam, not overridable)
// PORTS
//   clk        in   1      single clock, rising edge
//   rst        in   1      asynchronous, active-high reset
//   in_valid   in   1      bin set present
//   in_ready   out  1      block can accept a bin set
//   in_re_0..3 in   DW     real part of X0..X3, signed
//   in_im_0..3 in   DW     imag part of X0..X3, signed
//   out_valid  out  1      result present
//   out_ready  in   1      consumer accepts result
//   out_re_0..3 out DW     real part of x0..x3 after /4, signed
//   out_bits   out  4      out_bits[n] = out_re_n[0]; reconstructed fft2 input word
//   out_err    out  1      inexact-inverse flag (see CONFIGURATION)
// BEHAVIOUR
//   Reset (async, rst=1): state=IDLE; in_ready=0 while rst high, then 1; out_valid=0;
//     out_re_*, out_bits, out_err and all stage registers =0. In-flight set discarded.
//   FSM: IDLE -> (in_valid&in_ready) -> ST1 -> ST2 -> DONE -> (out_ready) -> IDLE.
//   in_ready=1 only in IDLE. Inputs captured into stage regs on the accept edge.
//   ST1 (1 cycle): a0=X0+X2, a1=X0-X2, a2=X1+X3, a3=X1-X3 (complex, DW+2 bits, sign-extended).
//   ST2 (1 cycle): y0=a0+a2, y2=a0-a2, y1=a1+j*a3, y3=a1-j*a3
//     (j*(r+ji) = -i+jr: y1.re=a1.re-a3.im, y3.re=a1.re+a3.im).
//   Scale: out_re_n = y_n.re >>> 2 (arithmetic), truncated to DW; registered on entry to DONE.
//   Latency: accept edge at cycle 0 -> out_valid=1 at cycle 3. Throughput 1 set / 4 cycles min.
//   DONE: out_valid=1; out_* stable until handshake; out_ready=0 holds indefinitely.
//   out_ready sampled only in DONE; ignored elsewhere. in_valid ignored outside IDLE.
//   Handshake edge in DONE: out_valid->0 next cycle, state->IDLE; no same-cycle new accept.
//   No overflow possible: |y|<=4*(2^(DW-1)) fits DW+2 signed; /4 result fits DW.
// CONFIGURATION
//   IFFT4_EXACT_CHK_EN defined: out_err registered with out_re_* at DONE entry;
//     out_err=1 if any y_n.re[1:0]!=0 or any y_n.im!=0 (bins are not the transform
//     of a real integer sequence); cleared on output handshake and on reset.
//   Not defined: out_err tied to 0, check logic absent.
// STRUCTURE
//   Package ifft4_pkg: DW default, state enum {IDLE,ST1,ST2,DONE}, complex struct
//     {re,im} of DW+2 bits, sign-extension function.
//   One sub-module: cbfly (combinational complex radix-2 butterfly, a+b / a-b),
//     instantiated for ST1 pairs and ST2 pairs; +/-j rotation done inline in top.
// TESTING
//   1) Reset mid-ST2 (rst pulse after accept) -> out_valid=0, all outputs 0, in_ready=1 after release.
//   2) X=(1,1,1,1) all im=0 (fft2 of 4'b0001) -> out_re=(1,0,0,0), out_bits=4'b0001, out_err=0, cycle 3.
//   3) X=(4,0,0,0) (fft2 of 4'b1111) -> out_re all 1, out_bits=4'b1111.
//   4) X=(1,-j,-1,+j) (fft2 of 4'b0010) -> out_bits=4'b0010, out_re_1=1, others 0.
//   5) Result ready, out_ready=0 for 10 cycles, in_valid=1 throughout -> outputs stable,
//      in_ready=0; out_ready=1 -> IDLE next edge, new set accepted after.
//   6) With IFFT4_EXACT_CHK_EN: X=(1,0,0,0) -> out_err=1, out_re all 0; without macro out_err=0.
//   Sweep: all 16 inputs through fft2 -> ifft4_seq; out_bits equals inp, out_err=0 for each.

Source files
------------

// File: rtl/ifft4_pkg.sv
// ifft4_pkg: shared state encoding, default width and complex type for ifft4_seq.
package ifft4_pkg;
  localparam int DW_DEF = 4;
  localparam int AW_DEF = DW_DEF + 2;
  typedef enum logic [1:0] {IDLE, ST1, ST2, DONE} state_t;
  typedef struct packed {
    logic signed [AW_DEF-1:0] re;
    logic signed [AW_DEF-1:0] im;
  } cplx_t;
  function automatic cplx_t sext(input logic signed [DW_DEF-1:0] re, input logic signed [DW_DEF-1:0] im);
    return '{re: AW_DEF'(re), im: AW_DEF'(im)};
  endfunction
endpackage

// File: rtl/ifft4_seq_cbfly.sv
// cbfly: combinational complex radix-2 butterfly producing a+b and a-b.
module cbfly #(
  parameter int W = 6
) (
  input  logic signed [W-1:0] i_a_re,
  input  logic signed [W-1:0] i_a_im,
  input  logic signed [W-1:0] i_b_re,
  input  logic signed [W-1:0] i_b_im,
  output logic signed [W-1:0] o_s_re,
  output logic signed [W-1:0] o_s_im,
  output logic signed [W-1:0] o_d_re,
  output logic signed [W-1:0] o_d_im
);
  assign o_s_re = i_a_re + i_b_re;
  assign o_s_im = i_a_im + i_b_im;
  assign o_d_re = i_a_re - i_b_re;
  assign o_d_im = i_a_im - i_b_im;
endmodule

// File: rtl/ifft4_seq.sv
// ifft4_seq: sequential 4-point inverse FFT, two butterfly stages then /4 scaling.
// Define IFFT4_EXACT_CHK_EN to flag bin sets that are not the transform of a real integer sequence.
module ifft4_seq
  import ifft4_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_re_0,
  input  logic signed [DW-1:0] in_re_1,
  input  logic signed [DW-1:0] in_re_2,
  input  logic signed [DW-1:0] in_re_3,
  input  logic signed [DW-1:0] in_im_0,
  input  logic signed [DW-1:0] in_im_1,
  input  logic signed [DW-1:0] in_im_2,
  input  logic signed [DW-1:0] in_im_3,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_re_0,
  output logic signed [DW-1:0] out_re_1,
  output logic signed [DW-1:0] out_re_2,
  output logic signed [DW-1:0] out_re_3,
  output logic [3:0]           out_bits,
  output logic                 out_err
);
  localparam int AW = DW + 2;
  typedef struct packed {
    logic signed [AW-1:0] re;
    logic signed [AW-1:0] im;
  } cx_t;
  state_t r_state, w_next;
  cx_t r_x [4];
  cx_t r_a [4];
  cx_t w_a [4];
  cx_t w_y [4];
  logic signed [DW-1:0] r_re [4];
  logic w_acc;
  always_comb begin
    in_ready = (r_state == IDLE) && !rst;
    out_valid = (r_state == DONE);
    w_acc = in_valid && in_ready;
    w_next = (r_state == IDLE) ? (w_acc ? ST1 : IDLE) :
             (r_state == ST1)  ? ST2 :
             (r_state == ST2)  ? DONE :
             (out_ready ? IDLE : DONE);
  end
  // stage 1 pairs (x0,x2)->a0,a1 and (x1,x3)->a2,a3
  for (genvar g = 0; g < 2; g++) begin : g_st1
    cbfly #(.W(AW)) u_bf (
      .i_a_re(r_x[g].re), .i_a_im(r_x[g].im), .i_b_re(r_x[g+2].re), .i_b_im(r_x[g+2].im),
      .o_s_re(w_a[2*g].re), .o_s_im(w_a[2*g].im), .o_d_re(w_a[2*g+1].re), .o_d_im(w_a[2*g+1].im)
    );
  end
  cbfly #(.W(AW)) u_st2 (
    .i_a_re(r_a[0].re), .i_a_im(r_a[0].im), .i_b_re(r_a[2].re), .i_b_im(r_a[2].im),
    .o_s_re(w_y[0].re), .o_s_im(w_y[0].im), .o_d_re(w_y[2].re), .o_d_im(w_y[2].im)
  );
  assign w_y[1] = '{re: r_a[1].re - r_a[3].im, im: r_a[1].im + r_a[3].re};
  assign w_y[3] = '{re: r_a[1].re + r_a[3].im, im: r_a[1].im - r_a[3].re};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_x <= '{default: '0};
      r_a <= '{default: '0};
      r_re <= '{default: '0};
    end else begin
      r_state <= w_next;
      if (w_acc)
        r_x <= '{'{AW'(in_re_0), AW'(in_im_0)}, '{AW'(in_re_1), AW'(in_im_1)},
                 '{AW'(in_re_2), AW'(in_im_2)}, '{AW'(in_re_3), AW'(in_im_3)}};
      if (r_state == ST1) r_a <= w_a;
      if (r_state == ST2)
        for (int i = 0; i < 4; i++) r_re[i] <= DW'(w_y[i].re >>> 2);
    end
  end
`ifdef IFFT4_EXACT_CHK_EN
  logic r_err, w_err;
  always_comb begin
    w_err = 1'b0;
    for (int i = 0; i < 4; i++) w_err = w_err | (|w_y[i].re[1:0]) | (|w_y[i].im);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_err <= 1'b0;
    else if (r_state == ST2) r_err <= w_err;
    else if (r_state == DONE && out_ready) r_err <= 1'b0;
  end
  assign out_err = r_err;
`else
  logic w_unused;
  assign w_unused = ^{w_y[0].im, w_y[1].im, w_y[2].im, w_y[3].im,
                      w_y[0].re[1:0], w_y[1].re[1:0], w_y[2].re[1:0], w_y[3].re[1:0]};
  assign out_err = 1'b0;
`endif
  assign out_re_0 = r_re[0];
  assign out_re_1 = r_re[1];
  assign out_re_2 = r_re[2];
  assign out_re_3 = r_re[3];
  assign out_bits = {r_re[3][0], r_re[2][0], r_re[1][0], r_re[0][0]};
endmodule

// File: tb/tb_ifft4_seq.sv
// tb_ifft4_seq: directed and randomized bin sets checked against a direct inverse-DFT model.
module tb_ifft4_seq;
  localparam int DW = 4;
`ifdef IFFT4_EXACT_CHK_EN
  localparam int EXP_T6 = 1;
`else
  localparam int EXP_T6 = 0;
`endif
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic signed [DW-1:0] in_re_0 = '0, in_re_1 = '0, in_re_2 = '0, in_re_3 = '0;
  logic signed [DW-1:0] in_im_0 = '0, in_im_1 = '0, in_im_2 = '0, in_im_3 = '0;
  logic in_ready, out_valid, out_err;
  logic signed [DW-1:0] out_re_0, out_re_1, out_re_2, out_re_3;
  logic [3:0] out_bits;
  int n_tests = 0, n_fail = 0;
  int vr [4];
  int vi [4];
  int got_bits, got_err;

  ifft4_seq #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_re_0(in_re_0), .in_re_1(in_re_1), .in_re_2(in_re_2), .in_re_3(in_re_3),
    .in_im_0(in_im_0), .in_im_1(in_im_1), .in_im_2(in_im_2), .in_im_3(in_im_3),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_re_0(out_re_0), .out_re_1(out_re_1), .out_re_2(out_re_2), .out_re_3(out_re_3),
    .out_bits(out_bits), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // x_n = (1/4) * sum_k X_k * e^{+j*2*pi*k*n/4}, floor-divided, plus exactness flag
  function automatic void model(output int er [4], output int ee, output int eb);
    int c [4];
    int s [4];
    int yr, yi, m;
    c = '{1, 0, -1, 0};
    s = '{0, 1, 0, -1};
    ee = 0;
    eb = 0;
    for (int n = 0; n < 4; n++) begin
      yr = 0;
      yi = 0;
      for (int k = 0; k < 4; k++) begin
        m = (k * n) % 4;
        yr += vr[k] * c[m] - vi[k] * s[m];
        yi += vr[k] * s[m] + vi[k] * c[m];
      end
      er[n] = yr >>> 2;
      eb |= (er[n] & 1) << n;
`ifdef IFFT4_EXACT_CHK_EN
      if ((yr & 3) != 0 || yi != 0) ee = 1;
`endif
    end
  endfunction

  // forward 4-point DFT of a 4-bit word, as the upstream fft2 would produce
  task automatic set_fft2(input int inp);
    int c [4];
    int s [4];
    c = '{1, 0, -1, 0};
    s = '{0, 1, 0, -1};
    for (int k = 0; k < 4; k++) begin
      vr[k] = 0;
      vi[k] = 0;
      for (int n = 0; n < 4; n++) begin
        vr[k] += ((inp >> n) & 1) * c[(k * n) % 4];
        vi[k] -= ((inp >> n) & 1) * s[(k * n) % 4];
      end
    end
  endtask

  task automatic present();
    int n = 0;
    @(negedge clk);
    in_re_0 = DW'(vr[0]); in_re_1 = DW'(vr[1]); in_re_2 = DW'(vr[2]); in_re_3 = DW'(vr[3]);
    in_im_0 = DW'(vi[0]); in_im_1 = DW'(vi[1]); in_im_2 = DW'(vi[2]); in_im_3 = DW'(vi[3]);
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", int'(in_ready), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic xfer(input int hold);
    int er [4];
    int ee, eb;
    model(er, ee, eb);
    present();
    @(negedge clk);
    @(negedge clk);
    check("lat_st2", int'(out_valid), 0);
    @(negedge clk);
    check("lat_done", int'(out_valid), 1);
    if (hold > 0) begin
      in_valid = 1'b1;
      in_re_0 = ~in_re_0;
    end
    for (int h = 0; h <= hold; h++) begin
      check("re0", int'(out_re_0), er[0]);
      check("re1", int'(out_re_1), er[1]);
      check("re2", int'(out_re_2), er[2]);
      check("re3", int'(out_re_3), er[3]);
      check("bits", int'(out_bits), eb);
      check("err", int'(out_err), ee);
      check("done_valid", int'(out_valid), 1);
      check("done_in_ready", int'(in_ready), 0);
      if (h < hold) @(negedge clk);
    end
    got_bits = int'(out_bits);
    got_err = int'(out_err);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("hs_valid", int'(out_valid), 0);
    check("hs_in_ready", int'(in_ready), 1);
    check("hs_err", int'(out_err), 0);
    in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    @(negedge clk);
    check("rst_hold_in_ready", int'(in_ready), 0);
    check("rst_hold_valid", int'(out_valid), 0);
    check("rst_hold_bits", int'(out_bits), 0);
    check("rst_hold_err", int'(out_err), 0);
    rst = 1'b0;
    #1 check("rst_rel_in_ready", int'(in_ready), 1);
    vr = '{1, 1, 1, 1}; vi = '{0, 0, 0, 0};
    xfer(0);
    check("t2_bits", got_bits, 4'b0001);
    check("t2_err", got_err, 0);
    vr = '{4, 0, 0, 0}; vi = '{0, 0, 0, 0};
    xfer(0);
    check("t3_bits", got_bits, 4'b1111);
    present();
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_in_ready", int'(in_ready), 0);
    check("midrst_re0", int'(out_re_0), 0);
    check("midrst_re1", int'(out_re_1), 0);
    check("midrst_re2", int'(out_re_2), 0);
    check("midrst_re3", int'(out_re_3), 0);
    check("midrst_bits", int'(out_bits), 0);
    check("midrst_err", int'(out_err), 0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("midrst_rel_in_ready", int'(in_ready), 1);
    @(negedge clk);
    check("midrst_idle_valid", int'(out_valid), 0);
    vr = '{1, 0, -1, 0}; vi = '{0, -1, 0, 1};
    xfer(0);
    check("t4_bits", got_bits, 4'b0010);
    vr = '{1, 1, 1, 1}; vi = '{0, 0, 0, 0};
    xfer(10);
    check("t5_bits", got_bits, 4'b0001);
    vr = '{4, 0, 0, 0}; vi = '{0, 0, 0, 0};
    xfer(0);
    check("t5_next_bits", got_bits, 4'b1111);
    vr = '{1, 0, 0, 0}; vi = '{0, 0, 0, 0};
    xfer(0);
    check("t6_err", got_err, EXP_T6);
    check("t6_bits", got_bits, 0);
    for (int inp = 0; inp < 16; inp++) begin
      set_fft2(inp);
      xfer(0);
      check("sweep_bits", got_bits, inp);
      check("sweep_err", got_err, 0);
    end
    repeat (40) begin
      for (int k = 0; k < 4; k++) begin
        vr[k] = int'($urandom_range(0, 15)) - 8;
        vi[k] = int'($urandom_range(0, 15)) - 8;
      end
      xfer(int'($urandom_range(0, 2)));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
